// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an IDLE/RUN/STEP/HALTED control FSM.
// In RUN the PC advances every unstalled cycle. In STEP the PC advances once per
// i_step request. Branch and jump inputs redirect the PC, and HALT freezes it.
//
// Optional feature: define PC_SEQ_CYCLE_COUNT_EN to enable the saturating
// advance counter on o_cycle_count. Without it, o_cycle_count is tied to 0.
//
// Ports:
//   i_clock, i_reset       clock; synchronous active-low reset
//   i_start, i_step_mode   leave IDLE into RUN (0) or STEP (1)
//   i_step                 request a single advance in STEP
//   i_stall                hold the PC (advance and redirect blocked)
//   i_branch_taken/_addr   redirect target, highest priority
//   i_jump/_addr           redirect target, second priority
//   i_halt, i_clear        enter HALTED / return from HALTED to IDLE
//   o_pc, o_pc_enable      registered PC and its update strobe
//   o_state                IDLE=0, RUN=1, STEP=2, HALTED=3
//   o_cycle_count          number of advances (feature-dependent)
module pc_sequencer #(
  parameter int unsigned        N_BITS   = 32,
  parameter logic [N_BITS-1:0]  PC_INC   = N_BITS'(1),
  parameter logic [N_BITS-1:0]  RESET_PC = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [N_BITS-1:0] i_branch_addr,
  input  logic              i_jump,
  input  logic [N_BITS-1:0] i_jump_addr,
  input  logic              i_halt,
  input  logic              i_clear,
  output logic [N_BITS-1:0] o_pc,
  output logic              o_pc_enable,
  output logic [1:0]        o_state,
  output logic [N_BITS-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state;
  logic [N_BITS-1:0] pc;
  logic              pc_enable;
  logic              pending;

  logic              advance_c;
  logic [N_BITS-1:0] next_pc_c;

  // Advance qualifier: halt overrides everything, and stall blocks both advance and redirect.
  always_comb begin
    advance_c = 1'b0;
    if (!i_halt && !i_stall) begin
      advance_c = (state == RUN) || ((state == STEP) && pending);
    end
  end

  // Next-PC select: branch > jump > sequential, with the sum wrapping modulo 2^N_BITS.
  always_comb begin
    next_pc_c = pc + PC_INC;
    if (i_branch_taken) begin
      next_pc_c = i_branch_addr;
    end else if (i_jump) begin
      next_pc_c = i_jump_addr;
    end
  end

  // Control FSM with registered PC, enable and step-pending flag.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pc_enable <= 1'b0;
      pending   <= 1'b0;
    end else begin
      pc_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= i_step_mode ? STEP : RUN;
          end
        end
        RUN, STEP: begin
          if (i_halt) begin
            state   <= HALTED;
            pending <= 1'b0;
          end else if (advance_c) begin
            pc        <= next_pc_c;
            pc_enable <= 1'b1;
            pending   <= 1'b0;
          end else if ((state == STEP) && i_step) begin
            // At most one request is held; repeats while pending are absorbed.
            pending <= 1'b1;
          end
        end
        HALTED: begin
          if (i_clear) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            pc_enable <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_pc        = pc;
  assign o_pc_enable = pc_enable;
  assign o_state     = state;

`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [N_BITS-1:0] cycle_count;

  // Saturating advance counter, cleared along with the PC on i_clear.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cycle_count <= '0;
    end else if ((state == HALTED) && i_clear) begin
      cycle_count <= '0;
    end else if (advance_c && !(&cycle_count)) begin
      cycle_count <= cycle_count + N_BITS'(1);
    end
  end

  assign o_cycle_count = cycle_count;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, randomized run against a
// behavioural model, and a wrap/reset check on an 8-bit all-ones RESET_PC instance.
module tb_pc_sequencer;

`ifdef PC_SEQ_CYCLE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, mode, step, stall, br, jmp, halt, clr;
  logic [31:0] ba, ja;
  logic [31:0] pc, cnt;
  logic        en;
  logic [1:0]  st;

  logic        w_rst_n, w_start;
  logic [7:0]  w_pc, w_cnt;
  logic        w_en;
  logic [1:0]  w_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_step_mode(mode),
    .i_step(step), .i_stall(stall), .i_branch_taken(br), .i_branch_addr(ba),
    .i_jump(jmp), .i_jump_addr(ja), .i_halt(halt), .i_clear(clr),
    .o_pc(pc), .o_pc_enable(en), .o_state(st), .o_cycle_count(cnt)
  );

  pc_sequencer #(.N_BITS(8), .PC_INC(8'd1), .RESET_PC(8'hFF)) dut_w (
    .i_clock(clk), .i_reset(w_rst_n), .i_start(w_start), .i_step_mode(1'b0),
    .i_step(1'b0), .i_stall(1'b0), .i_branch_taken(1'b0), .i_branch_addr(8'h00),
    .i_jump(1'b0), .i_jump_addr(8'h00), .i_halt(1'b0), .i_clear(1'b0),
    .o_pc(w_pc), .o_pc_enable(w_en), .o_state(w_st), .o_cycle_count(w_cnt)
  );

  typedef struct {
    bit          r, s, m, sp, sl, b, j, h, c;
    logic [31:0] ba, ja;
    logic [31:0] e_pc;
    bit          e_en;
    logic [1:0]  e_st;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit s, bit m, bit sp, bit sl, bit b, bit j, bit h, bit c,
                             logic [31:0] a_b, logic [31:0] a_j,
                             logic [31:0] e_pc, bit e_en, logic [1:0] e_st, logic [31:0] e_cnt);
    vec_t x;
    x.r = r; x.s = s; x.m = m; x.sp = sp; x.sl = sl; x.b = b; x.j = j; x.h = h; x.c = c;
    x.ba = a_b; x.ja = a_j; x.e_pc = e_pc; x.e_en = e_en; x.e_st = e_st; x.e_cnt = e_cnt;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst_n = x.r; start = x.s; mode = x.m; step = x.sp; stall = x.sl;
    br = x.b; jmp = x.j; halt = x.h; clr = x.c; ba = x.ba; ja = x.ja;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: state is the spec's numeric state code, advance is decided from the rules.
  int          m_st;
  logic [31:0] m_pc, m_cnt;
  bit          m_en, m_pend;

  task automatic model_edge();
    bit adv = 1'b0;
    m_en = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_pc = 32'h0; m_cnt = 32'h0; m_pend = 1'b0;
      return;
    end
    if (m_st == 0) begin
      if (start) m_st = mode ? 2 : 1;
    end else if (m_st == 3) begin
      if (clr) begin m_st = 0; m_pc = 32'h0; m_en = 1'b1; m_cnt = 32'h0; end
    end else if (halt) begin
      m_st = 3; m_pend = 1'b0;
    end else if (m_st == 1) begin
      adv = !stall;
    end else if (m_pend && !stall) begin
      adv = 1'b1; m_pend = 1'b0;
    end else if (step) begin
      m_pend = 1'b1;
    end
    if (adv) begin
      m_pc = br ? ba : (jmp ? ja : m_pc + 32'd1);
      m_en = 1'b1;
      if (CNT_ON && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  endtask

  initial begin
    vec_t x;
    w_rst_n = 1'b0; w_start = 1'b0;
    drive(v(0,0,0,0,0,0,0,0,0, 0,0, 0,0,0,0));

    // Run from reset, count up to 8, then redirect, stall, halt and clear.
    vecs.push_back(v(0,0,0,0,0,0,0,0,0, 0,0, 0,0,0,0));
    vecs.push_back(v(1,1,0,0,0,0,0,0,0, 0,0, 0,0,1,0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(1,0,0,0,0,0,0,0,0, 0,0, 32'(i),1,1,32'(i)));
    vecs.push_back(v(1,0,0,0,1,0,0,0,0, 0,0, 8,0,1,8));
    vecs.push_back(v(1,0,0,0,0,1,1,0,0, 32'h40,32'h80, 32'h40,1,1,9));
    vecs.push_back(v(1,0,0,0,0,0,1,0,0, 0,32'h80, 32'h80,1,1,10));
    vecs.push_back(v(1,0,0,0,1,1,0,0,0, 32'h10,0, 32'h80,0,1,10));
    vecs.push_back(v(1,0,0,0,0,1,0,0,0, 32'h10,0, 32'h10,1,1,11));
    vecs.push_back(v(1,0,0,0,0,1,0,1,0, 32'h20,0, 32'h10,0,3,11));
    vecs.push_back(v(1,1,0,1,0,0,1,0,0, 0,32'h50, 32'h10,0,3,11));
    vecs.push_back(v(1,0,0,0,0,0,0,0,1, 0,0, 0,1,0,0));
    vecs.push_back(v(1,0,0,1,1,1,1,1,0, 32'h7,32'h9, 0,0,0,0));
    // Single-step: request under a 4-cycle stall with a repeat request, then release.
    vecs.push_back(v(1,1,1,0,0,0,0,0,0, 0,0, 0,0,2,0));
    vecs.push_back(v(1,0,0,1,1,0,0,0,0, 0,0, 0,0,2,0));
    vecs.push_back(v(1,0,0,0,1,0,0,0,0, 0,0, 0,0,2,0));
    vecs.push_back(v(1,0,0,1,1,0,0,0,0, 0,0, 0,0,2,0));
    vecs.push_back(v(1,0,0,0,1,0,0,0,0, 0,0, 0,0,2,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0, 0,0, 1,1,2,1));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0, 0,0, 1,0,2,1));
    vecs.push_back(v(1,0,0,1,0,0,0,0,0, 0,0, 1,0,2,1));
    vecs.push_back(v(1,0,0,0,0,0,1,0,0, 0,32'h33, 32'h33,1,2,2));
    vecs.push_back(v(1,0,0,1,0,0,0,0,0, 0,0, 32'h33,0,2,2));
    vecs.push_back(v(1,0,0,0,1,0,0,1,0, 0,0, 32'h33,0,3,2));
    vecs.push_back(v(1,0,0,0,0,0,0,0,1, 0,0, 0,1,0,0));
    // Reset while running and stalled.
    vecs.push_back(v(1,1,0,0,0,0,0,0,0, 0,0, 0,0,1,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0, 0,0, 1,1,1,1));
    vecs.push_back(v(0,1,0,0,1,1,0,0,0, 32'h44,0, 0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0,0, 0,0, 0,0,0,0));

    foreach (vecs[i]) begin
      x = vecs[i];
      drive(x);
      tick();
      chk("vec_pc", i, pc, x.e_pc);
      chk("vec_en", i, 32'(en), 32'(x.e_en));
      chk("vec_state", i, 32'(st), 32'(x.e_st));
      chk("vec_count", i, cnt, CNT_ON ? x.e_cnt : 32'h0);
    end

    // Randomized run against the model, starting from a reset.
    rst_n = 1'b0;
    model_edge();
    tick();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom_range(0, 1));
      step  = ($urandom_range(0, 2) == 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 5) == 0);
      jmp   = ($urandom_range(0, 5) == 0);
      halt  = ($urandom_range(0, 39) == 0);
      clr   = ($urandom_range(0, 3) == 0);
      ba    = $urandom;
      ja    = $urandom;
      model_edge();
      tick();
      chk("rnd_pc", i, pc, m_pc);
      chk("rnd_en", i, 32'(en), 32'(m_en));
      chk("rnd_state", i, 32'(st), 32'(m_st));
      chk("rnd_count", i, cnt, m_cnt);
    end

    // All-ones reset PC wraps to 0 on the first advance; a reset mid-run reloads it.
    w_rst_n = 1'b0; tick();
    chk("wrap_reset_pc", 0, 32'(w_pc), 32'hFF);
    chk("wrap_reset_state", 0, 32'(w_st), 32'd0);
    w_rst_n = 1'b1; w_start = 1'b1; tick();
    chk("wrap_start_pc", 0, 32'(w_pc), 32'hFF);
    chk("wrap_start_state", 0, 32'(w_st), 32'd1);
    w_start = 1'b0; tick();
    chk("wrap_pc", 0, 32'(w_pc), 32'h00);
    chk("wrap_en", 0, 32'(w_en), 32'd1);
    chk("wrap_count", 0, 32'(w_cnt), CNT_ON ? 32'd1 : 32'd0);
    tick();
    chk("wrap_pc_next", 0, 32'(w_pc), 32'h01);
    w_rst_n = 1'b0; tick();
    chk("wrap_midrun_pc", 0, 32'(w_pc), 32'hFF);
    chk("wrap_midrun_state", 0, 32'(w_st), 32'd0);
    chk("wrap_midrun_en", 0, 32'(w_en), 32'd0);
    chk("wrap_midrun_count", 0, 32'(w_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
